// File: rtl/avalon_mem_responder.sv
// Avalon-MM slave RAM with programmable read/write wait states.
// Serves one single-word access at a time and counts completed reads and writes.
module avalon_mem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int READ_WAIT  = 2,
    parameter int WRITE_WAIT = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  avs_s1_chipselect,
    input  logic [ADDR_WIDTH-1:0] avs_s1_address,
    input  logic                  avs_s1_read,
    input  logic                  avs_s1_write,
    input  logic [31:0]           avs_s1_writedata,
    input  logic [3:0]            avs_s1_byteenable,
    output logic [31:0]           avs_s1_readdata,
    output logic                  avs_s1_waitrequest,
    output logic [15:0]           rd_count,
    output logic [15:0]           wr_count,
    output logic                  proto_err,
    input  logic                  clr_err
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    localparam int         DEPTH   = 1 << ADDR_WIDTH;
    localparam logic [3:0] RD_WAIT = 4'(READ_WAIT);
    localparam logic [3:0] WR_WAIT = 4'(WRITE_WAIT);

    state_t                state;
    logic [3:0]            wait_cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [3:0]            be_q;
    logic                  op_write;

    logic [31:0]           mem [DEPTH];

    logic                  request;
    logic [3:0]            req_wait;
    logic                  op_drop;
    logic                  commit;
    logic                  c_write;
    logic [ADDR_WIDTH-1:0] c_addr;
    logic [31:0]           c_data;
    logic [3:0]            c_be;

    assign request  = avs_s1_chipselect & (avs_s1_read | avs_s1_write);
    assign req_wait = avs_s1_write ? WR_WAIT : RD_WAIT;
    assign op_drop  = !avs_s1_chipselect || (op_write ? !avs_s1_write : !avs_s1_read);

    // commit is high on the edge that enters ACK; a zero-wait access commits
    // straight from the live bus, otherwise from the values latched in IDLE.
    always_comb begin
        commit  = 1'b0;
        c_write = op_write;
        c_addr  = addr_q;
        c_data  = wdata_q;
        c_be    = be_q;
        case (state)
            S_IDLE: begin
                c_write = avs_s1_write;
                c_addr  = avs_s1_address;
                c_data  = avs_s1_writedata;
                c_be    = avs_s1_byteenable;
                commit  = request && (req_wait == 4'd0);
            end
            S_WAIT: commit = !op_drop && (wait_cnt == 4'd1);
            default: commit = 1'b0;
        endcase
        if (reset) begin
            commit = 1'b0;
        end
    end

    // RAM is deliberately not reset so contents survive a reset.
    always_ff @(posedge clk) begin
        if (commit && c_write) begin
            for (int i = 0; i < 4; i++) begin
                if (c_be[i]) begin
                    mem[c_addr][8*i +: 8] <= c_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= S_IDLE;
            wait_cnt           <= 4'd0;
            addr_q             <= '0;
            wdata_q            <= 32'd0;
            be_q               <= 4'd0;
            op_write           <= 1'b0;
            avs_s1_waitrequest <= 1'b1;
            avs_s1_readdata    <= 32'd0;
            rd_count           <= 16'd0;
            wr_count           <= 16'd0;
            proto_err          <= 1'b0;
        end else begin
            avs_s1_waitrequest <= !commit;
            if (commit) begin
                if (c_write) begin
                    wr_count <= wr_count + 16'd1;
                end else begin
                    rd_count        <= rd_count + 16'd1;
                    avs_s1_readdata <= mem[c_addr];
                end
            end

            case (state)
                S_IDLE: begin
                    if (request) begin
                        addr_q   <= avs_s1_address;
                        wdata_q  <= avs_s1_writedata;
                        be_q     <= avs_s1_byteenable;
                        op_write <= avs_s1_write;
                        wait_cnt <= req_wait;
                        state    <= (req_wait == 4'd0) ? S_ACK : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (op_drop) begin
                        state <= S_IDLE;
                    end else if (wait_cnt == 4'd1) begin
                        state <= S_ACK;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                S_ACK:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase

            // clr_err wins over any error detected in the same cycle.
            if (clr_err) begin
                proto_err <= 1'b0;
            end else if ((state == S_IDLE && avs_s1_chipselect && avs_s1_read && avs_s1_write) ||
                         (state == S_WAIT && op_drop)) begin
                proto_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_avalon_mem_responder.sv
// Scoreboard bench for avalon_mem_responder: the driver queues expected ACKs,
// a negedge monitor pops and checks latency and readdata on every ACK.
module tb_avalon_mem_responder;

    localparam int AW = 10;
    localparam int RW = 2;
    localparam int WW = 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          chipselect;
    logic [AW-1:0] address;
    logic          read;
    logic          write;
    logic [31:0]   writedata;
    logic [3:0]    byteenable;
    logic [31:0]   readdata;
    logic          waitrequest;
    logic [15:0]   rd_count;
    logic [15:0]   wr_count;
    logic          proto_err;
    logic          clr_err;

    avalon_mem_responder #(.ADDR_WIDTH(AW), .READ_WAIT(RW), .WRITE_WAIT(WW)) dut (
        .clk                (clk),
        .reset              (reset),
        .avs_s1_chipselect  (chipselect),
        .avs_s1_address     (address),
        .avs_s1_read        (read),
        .avs_s1_write       (write),
        .avs_s1_writedata   (writedata),
        .avs_s1_byteenable  (byteenable),
        .avs_s1_readdata    (readdata),
        .avs_s1_waitrequest (waitrequest),
        .rd_count           (rd_count),
        .wr_count           (wr_count),
        .proto_err          (proto_err),
        .clr_err            (clr_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_read;
        logic [31:0] data;
        int          ack_cycle;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          exp_rd = 0;
    int          exp_wr = 0;
    logic [31:0] last_rd = 32'd0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Every ACK must match the oldest queued expectation; readdata must still
    // hold the last read value even on write ACKs.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (waitrequest === 1'b0) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_ack: got ack expected none (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                checkOutput("ack_latency", 32'(cyc), 32'(e.ack_cycle));
                checkOutput(e.is_read ? "read_data" : "readdata_hold", readdata, e.data);
            end
        end
    end

    task automatic waitAck();
        bit acked = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (waitrequest === 1'b0) begin
                acked = 1;
                break;
            end
        end
        if (!acked) begin
            checks++;
            errors++;
            $display("[TB] FAIL ack_timeout: got no ack expected ack within 40 cycles");
        end
    endtask

    // Called #1 after a posedge; returns #1 after the edge that ends ACK with the bus idle.
    task automatic applyStimulus(input bit do_rd, input bit do_wr, input logic [AW-1:0] a,
                                 input logic [31:0] d, input logic [3:0] b, input logic [31:0] exp_read);
        exp_t e;
        chipselect = 1'b1;
        read       = do_rd;
        write      = do_wr;
        address    = a;
        writedata  = d;
        byteenable = b;
        e.is_read  = !do_wr;
        if (do_wr) begin
            exp_wr++;
            e.ack_cycle = cyc + 1 + WW;
        end else begin
            exp_rd++;
            last_rd     = exp_read;
            e.ack_cycle = cyc + 1 + RW;
        end
        e.data = last_rd;
        sb.push_back(e);
        waitAck();
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
    endtask

    task automatic pulseClear();
        clr_err = 1'b1;
        @(posedge clk);
        #1;
        clr_err = 1'b0;
    endtask

    logic [31:0] table8 [8];

    initial begin
        table8 = '{32'h1000_0000, 32'h1000_0001, 32'h1000_0002, 32'hDEAD_BEEF,
                   32'h1000_0004, 32'hA5A5_1234, 32'h1000_0006, 32'h11FF_33FF};
        reset      = 1'b1;
        chipselect = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        address    = '0;
        writedata  = 32'd0;
        byteenable = 4'd0;
        clr_err    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_waitrequest", 32'(waitrequest), 32'd1);
        checkOutput("reset_readdata", readdata, 32'd0);
        checkOutput("reset_rd_count", 32'(rd_count), 32'd0);
        checkOutput("reset_wr_count", 32'(wr_count), 32'd0);
        checkOutput("reset_proto_err", 32'(proto_err), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Full-word write then read-back with both latencies.
        applyStimulus(0, 1, 10'd5, 32'hA5A5_1234, 4'hF, 32'd0);
        applyStimulus(1, 0, 10'd5, 32'd0, 4'h0, 32'hA5A5_1234);
        checkOutput("t1_wr_count", 32'(wr_count), 32'd1);
        checkOutput("t1_rd_count", 32'(rd_count), 32'd1);

        // Partial byte-enable write.
        applyStimulus(0, 1, 10'd7, 32'h1122_3344, 4'hF, 32'd0);
        applyStimulus(0, 1, 10'd7, 32'hFFFF_FFFF, 4'b0101, 32'd0);
        applyStimulus(1, 0, 10'd7, 32'd0, 4'h0, 32'h11FF_33FF);

        for (int i = 0; i < 8; i++) begin
            if (i != 3 && i != 5 && i != 7) begin
                applyStimulus(0, 1, 10'(i), 32'h1000_0000 + 32'(i), 4'hF, 32'd0);
            end
        end

        // Read and write together: proceeds as a write, flags an error.
        applyStimulus(1, 1, 10'd3, 32'hDEAD_BEEF, 4'hF, 32'd0);
        checkOutput("t4_proto_err_set", 32'(proto_err), 32'd1);
        pulseClear();
        checkOutput("t4_proto_err_clr", 32'(proto_err), 32'd0);
        clr_err = 1'b1;
        applyStimulus(1, 1, 10'd3, 32'hDEAD_BEEF, 4'hF, 32'd0);
        clr_err = 1'b0;
        checkOutput("clr_priority", 32'(proto_err), 32'd0);

        // Zero byteenable write is acknowledged but changes nothing.
        applyStimulus(0, 1, 10'd5, 32'h0000_0000, 4'h0, 32'd0);
        checkOutput("be0_wr_count", 32'(wr_count), 32'(exp_wr));

        // Back-to-back reads 0..7.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, 0, 10'(i), 32'd0, 4'h0, table8[i]);
        end
        checkOutput("b2b_rd_count", 32'(rd_count), 32'(exp_rd));

        // Abort: chipselect dropped during WAIT of a write.
        applyStimulus(0, 1, 10'd9, 32'h0909_0909, 4'hF, 32'd0);
        chipselect = 1'b1;
        write      = 1'b1;
        address    = 10'd9;
        writedata  = 32'hFFFF_0000;
        byteenable = 4'hF;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write      = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("abort_proto_err", 32'(proto_err), 32'd1);
        checkOutput("abort_wr_count", 32'(wr_count), 32'(exp_wr));
        checkOutput("abort_waitrequest", 32'(waitrequest), 32'd1);
        applyStimulus(1, 0, 10'd9, 32'd0, 4'h0, 32'h0909_0909);
        pulseClear();

        // Reset during WAIT of a write discards it; RAM survives.
        chipselect = 1'b1;
        write      = 1'b1;
        address    = 10'd9;
        writedata  = 32'hBAD0_BAD0;
        byteenable = 4'hF;
        @(posedge clk);
        #1;
        reset      = 1'b1;
        chipselect = 1'b0;
        write      = 1'b0;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        exp_rd  = 0;
        exp_wr  = 0;
        last_rd = 32'd0;
        checkOutput("midreset_waitrequest", 32'(waitrequest), 32'd1);
        checkOutput("midreset_rd_count", 32'(rd_count), 32'd0);
        checkOutput("midreset_wr_count", 32'(wr_count), 32'd0);
        checkOutput("midreset_readdata", readdata, 32'd0);
        applyStimulus(1, 0, 10'd9, 32'd0, 4'h0, 32'h0909_0909);
        applyStimulus(1, 0, 10'd5, 32'd0, 4'h0, 32'hA5A5_1234);
        checkOutput("post_reset_rd_count", 32'(rd_count), 32'd2);

        repeat (5) @(posedge clk);
        #1;
        checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
